// File: rtl/frame_buf_pkg.sv
// Shared constants and writer state type for the frame buffer controller.
package frame_buf_pkg;
  localparam int WIN_W_DEF = 128;
  localparam int WIN_H_DEF = 128;
  localparam int ADDR_W    = 14;
  localparam int PIX_W     = 12;
  localparam int COORD_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } wr_state_t;
endpackage

// File: rtl/frame_buf_addr.sv
// Window membership test and {y[6:0],x[6:0]} VRAM address pack; shared by writer and reader.
module frame_buf_addr import frame_buf_pkg::*; #(
  parameter int WIN_W = WIN_W_DEF,
  parameter int WIN_H = WIN_H_DEF
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               in_win,
  output logic [ADDR_W-1:0]  addr
);
  assign in_win = (int'(x) < WIN_W) && (int'(y) < WIN_H);
  assign addr   = {y[6:0], x[6:0]};
endmodule

// File: rtl/frame_buf_ctrl.sv
// Camera-to-VRAM frame buffer controller with VGA read addressing.
// FRAME_BUF_DOUBLE_EN selects ping-pong banks; otherwise a single bank 0 is used.
//   state      | meaning
//   ST_IDLE    | waiting for camera vsync rising edge
//   ST_CAPTURE | writing in-window pixels to the back bank
//   ST_DONE    | back bank full, waiting for VGA frame end to swap
module frame_buf_ctrl import frame_buf_pkg::*; #(
  parameter int WIN_W    = WIN_W_DEF,
  parameter int WIN_H    = WIN_H_DEF,
  parameter int RD_X_OFS = 7
) (
  input  logic               m_clock,
  input  logic               p_reset,
  input  logic [COORD_W-1:0] cam_x,
  input  logic [COORD_W-1:0] cam_y,
  input  logic               cam_valid,
  input  logic [3:0]         cam_r,
  input  logic [3:0]         cam_g,
  input  logic [3:0]         cam_b,
  input  logic               cam_vsync,
  input  logic [COORD_W-1:0] vga_x,
  input  logic [COORD_W-1:0] vga_y,
  input  logic               vga_frame_end,
  output logic               wr_en,
  output logic               wr_bank,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIX_W-1:0]   wr_data,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_bank,
  output logic               rd_valid,
  output logic [7:0]         frame_cnt,
  output logic [7:0]         drop_cnt
);
  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(WIN_W - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(WIN_H - 1);

  wr_state_t          state, state_nx;
  logic               vsync_q, vs_rise;
  logic               wr_in_win, wr_hit, last_pix;
  logic [ADDR_W-1:0]  wr_addr_c, rd_addr_c;
  logic [COORD_W-1:0] rx;
  logic               rd_in_win, rd_win_q;
  logic               frame_inc, drop_inc, swap;

  assign vs_rise = cam_vsync & ~vsync_q;
  assign rx      = vga_x - COORD_W'(RD_X_OFS);

  frame_buf_addr #(.WIN_W(WIN_W), .WIN_H(WIN_H)) u_wr_addr (
    .x(cam_x), .y(cam_y), .in_win(wr_in_win), .addr(wr_addr_c)
  );

  frame_buf_addr #(.WIN_W(WIN_W), .WIN_H(WIN_H)) u_rd_addr (
    .x(rx), .y(vga_y), .in_win(rd_in_win), .addr(rd_addr_c)
  );

  assign wr_hit   = (state == ST_CAPTURE) && cam_valid && wr_in_win;
  assign last_pix = wr_hit && (cam_x == LAST_X) && (cam_y == LAST_Y);

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state   <= ST_IDLE;
      vsync_q <= 1'b0;
    end else begin
      state   <= state_nx;
      vsync_q <= cam_vsync;
    end
  end

  // A new vsync edge outranks completion: the frame is restarted, not counted.
  always_comb begin
    state_nx  = state;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    swap      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vs_rise) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (vs_rise) begin
          drop_inc = 1'b1;
        end else if (last_pix) begin
          frame_inc = 1'b1;
`ifdef FRAME_BUF_DOUBLE_EN
          state_nx  = ST_DONE;
`else
          state_nx  = ST_IDLE;
`endif
        end
      end
      ST_DONE: begin
        if (vga_frame_end) begin
          swap     = 1'b1;
          state_nx = vs_rise ? ST_CAPTURE : ST_IDLE;
        end else if (vs_rise) begin
          drop_inc = 1'b1;
          state_nx = ST_CAPTURE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= wr_hit;
      if (wr_hit) begin
        wr_addr <= wr_addr_c;
        wr_data <= {cam_r, cam_g, cam_b};
      end
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      frame_cnt <= 8'd0;
      drop_cnt  <= 8'd0;
    end else begin
      if (frame_inc) frame_cnt <= frame_cnt + 8'd1;
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Valid trails the address by one extra cycle to line up with VRAM q.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      rd_addr  <= '0;
      rd_win_q <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_addr  <= rd_addr_c;
      rd_win_q <= rd_in_win;
      rd_valid <= rd_win_q;
    end
  end

`ifdef FRAME_BUF_DOUBLE_EN
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      wr_bank <= 1'b1;
      rd_bank <= 1'b0;
    end else if (swap) begin
      rd_bank <= wr_bank;
      wr_bank <= ~wr_bank;
    end
  end
`else
  logic unused_swap;
  assign unused_swap = swap;
  assign wr_bank     = 1'b0;
  assign rd_bank     = 1'b0;
`endif
endmodule
